// File: rtl/idli_serial_alu_m.sv
// Slice-serial ALU: DATA_W operand processed SLICE_W bits per accepted beat, LSB slice first.
// Optional overflow/negative flags are built when IDLI_SALU_FLAGS_EN is defined.

module idli_salu_bit_m (
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       ci,
  output logic       d,
  output logic       co
);
  always_comb begin
    d  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
    case (op)
      2'd1: begin d = a & b; co = 1'b0; end
      2'd2: begin d = a | b; co = 1'b0; end
      2'd3: begin d = a ^ b; co = 1'b0; end
      default: ;
    endcase
  end
endmodule

module idli_serial_alu_m #(
  parameter int SLICE_W = 4,
  parameter int DATA_W  = 16
) (
  input  logic               i_salu_gck,
  input  logic               i_salu_rst_n,
  input  logic               i_salu_vld,
  input  logic [1:0]         i_salu_op,
  input  logic               i_salu_rhs_inv,
  input  logic               i_salu_cin,
  input  logic [SLICE_W-1:0] i_salu_lhs,
  input  logic [SLICE_W-1:0] i_salu_rhs,
  output logic               o_salu_vld,
  output logic [SLICE_W-1:0] o_salu_data,
  output logic               o_salu_last,
  output logic               o_salu_cout,
  output logic               o_salu_zero,
  output logic               o_salu_ovf,
  output logic               o_salu_neg
);
  localparam int N_SLICE = DATA_W / SLICE_W;
  localparam int CTR_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam int STAGES  = 1;
  localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(N_SLICE - 1);

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_OR = 2'd2, ALU_XOR = 2'd3} alu_op_t;
  typedef struct packed {
    alu_op_t op;
    logic    inv;
    logic    cin;
  } salu_ctl_t;

  generate
    if (DATA_W % SLICE_W != 0) begin : g_bad_width
      $error("idli_serial_alu_m: DATA_W must be a multiple of SLICE_W");
    end
  endgenerate

  logic [CTR_W-1:0]   ctr_q;
  logic               carry_q;
  logic               zrun_q;
  salu_ctl_t          ctl_q;
  salu_ctl_t          ctl_in;
  salu_ctl_t          ctl_eff;
  logic [STAGES:1]    vld_pipe;
  logic               first;
  logic               last;
  logic [SLICE_W-1:0] rhs_x;
  logic [SLICE_W-1:0] d;
  logic [SLICE_W:0]   cy;
  logic               zrun_nxt;

  // Slice 0 takes control straight from the ports; later slices replay the latched copy.
  always_comb begin
    ctl_in.op  = alu_op_t'(i_salu_op);
    ctl_in.inv = i_salu_rhs_inv;
    ctl_in.cin = i_salu_cin;
    first      = (ctr_q == '0);
    last       = (ctr_q == LAST_CTR);
    ctl_eff    = first ? ctl_in : ctl_q;
    rhs_x      = i_salu_rhs ^ {SLICE_W{ctl_eff.inv}};
    cy[0]      = first ? ctl_in.cin : carry_q;
  end

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    idli_salu_bit_m u_bit (
      .op (ctl_eff.op),
      .a  (i_salu_lhs[i]),
      .b  (rhs_x[i]),
      .ci (cy[i]),
      .d  (d[i]),
      .co (cy[i+1])
    );
  end

  assign zrun_nxt   = ~|d & (first | zrun_q);
  assign o_salu_vld = vld_pipe[STAGES];

  always_ff @(posedge i_salu_gck or negedge i_salu_rst_n) begin
    if (!i_salu_rst_n) begin
      ctr_q       <= '0;
      carry_q     <= 1'b0;
      zrun_q      <= 1'b1;
      ctl_q       <= '{op: ALU_ADD, inv: 1'b0, cin: 1'b0};
      vld_pipe    <= '0;
      o_salu_data <= '0;
      o_salu_last <= 1'b0;
      o_salu_cout <= 1'b0;
      o_salu_zero <= 1'b0;
    end else begin
      vld_pipe[1] <= i_salu_vld;
      o_salu_last <= i_salu_vld & last;
      if (i_salu_vld) begin
        ctr_q       <= last ? '0 : ctr_q + 1'b1;
        carry_q     <= cy[SLICE_W];
        zrun_q      <= zrun_nxt;
        o_salu_data <= d;
        if (first) ctl_q <= ctl_in;
        if (last) begin
          o_salu_cout <= cy[SLICE_W];
          o_salu_zero <= zrun_nxt;
        end
      end
    end
  end

`ifdef IDLI_SALU_FLAGS_EN
  // Signed overflow from the carries around the MSB of the final slice.
  always_ff @(posedge i_salu_gck or negedge i_salu_rst_n) begin
    if (!i_salu_rst_n) begin
      o_salu_ovf <= 1'b0;
      o_salu_neg <= 1'b0;
    end else if (i_salu_vld && last) begin
      o_salu_ovf <= (ctl_eff.op == ALU_ADD) & (cy[SLICE_W-1] ^ cy[SLICE_W]);
      o_salu_neg <= d[SLICE_W-1];
    end
  end
`else
  assign o_salu_ovf = 1'b0;
  assign o_salu_neg = 1'b0;
`endif

endmodule

// File: tb/tb_idli_serial_alu_m.sv
// Directed scoreboard bench for idli_serial_alu_m (SLICE_W=4, DATA_W=16).
module tb_idli_serial_alu_m;
  localparam int NS = 4;
`ifdef IDLI_SALU_FLAGS_EN
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam logic FLAGS_EN = 1'b0;
`endif
  localparam logic [1:0] OP_ADD = 2'd0, OP_AND = 2'd1, OP_OR = 2'd2, OP_XOR = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld = 1'b0;
  logic [1:0] op = 2'd0;
  logic       inv = 1'b0;
  logic       cin = 1'b0;
  logic [3:0] lhs = 4'h0;
  logic [3:0] rhs = 4'h0;
  logic       o_vld, o_last, o_cout, o_zero, o_ovf, o_neg;
  logic [3:0] o_data;

  typedef struct packed {
    logic [3:0] d;
    logic       last;
    logic       cout;
    logic       zero;
    logic       ovf;
    logic       neg;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_bad = 0, n_pushed = 0, n_seen = 0;
  logic h_cout = 1'b0, h_zero = 1'b0, h_ovf = 1'b0, h_neg = 1'b0;

  idli_serial_alu_m #(.SLICE_W(4), .DATA_W(16)) dut (
    .i_salu_gck     (clk),
    .i_salu_rst_n   (rst_n),
    .i_salu_vld     (vld),
    .i_salu_op      (op),
    .i_salu_rhs_inv (inv),
    .i_salu_cin     (cin),
    .i_salu_lhs     (lhs),
    .i_salu_rhs     (rhs),
    .o_salu_vld     (o_vld),
    .o_salu_data    (o_data),
    .o_salu_last    (o_last),
    .o_salu_cout    (o_cout),
    .o_salu_zero    (o_zero),
    .o_salu_ovf     (o_ovf),
    .o_salu_neg     (o_neg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired seen=%0d pushed=%0d", n_seen, n_pushed);
    $fatal(1, "watchdog");
  end

  // Monitor: every presented result beat pops one expected entry.
  initial begin
    exp_t act, e;
    forever begin
      @(posedge clk);
      #1;
      if (o_vld) begin
        act = '{d: o_data, last: o_last, cout: o_cout, zero: o_zero, ovf: o_ovf, neg: o_neg};
        n_seen++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat%0d unexpected output got d,l,c,z,v,n=%b want none", n_seen, act);
        end else begin
          e = sb_q.pop_front();
          if (act !== e) begin
            n_bad++;
            $display("FAIL beat%0d got d,l,c,z,v,n=%b want %b", n_seen, act, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {22'd0, o_vld, o_data, o_last, o_cout, o_zero, o_ovf, o_neg};
  endfunction

  // Drive nb slices; later slices carry junk control which the DUT must ignore.
  task automatic run_op(input logic [1:0] o, input logic iv, input logic ci,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                        input logic ecout, input logic ezero, input logic eovf, input logic eneg,
                        input logic [1:0] jop, input int nb, input int gap_at);
    exp_t e;
    for (int k = 0; k < nb; k++) begin
      e.d    = res[k*4 +: 4];
      e.last = (k == NS-1);
      if (k == NS-1) begin
        e.cout = ecout; e.zero = ezero; e.ovf = eovf & FLAGS_EN; e.neg = eneg & FLAGS_EN;
      end else begin
        e.cout = h_cout; e.zero = h_zero; e.ovf = h_ovf; e.neg = h_neg;
      end
      @(negedge clk);
      vld = 1'b1;
      op  = (k == 0) ? o : jop;
      inv = (k == 0) ? iv : ~iv;
      cin = (k == 0) ? ci : ~ci;
      lhs = a[k*4 +: 4];
      rhs = b[k*4 +: 4];
      sb_q.push_back(e);
      n_pushed++;
      if (k == gap_at) begin
        repeat (2) begin
          @(negedge clk);
          vld = 1'b0; op = jop; lhs = 4'hF; rhs = 4'h0;
        end
      end
    end
    if (nb == NS) begin
      h_cout = ecout; h_zero = ezero; h_ovf = eovf & FLAGS_EN; h_neg = eneg & FLAGS_EN;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0;
    end
  endtask

  initial begin
    @(negedge clk);
    chk("reset_state", all_outs(), 32'd0);
    rst_n = 1'b1;

    run_op(OP_ADD, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, OP_XOR, NS, -1);
    run_op(OP_ADD, 1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, OP_OR,  NS, -1);
    run_op(OP_ADD, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, OP_AND, NS, -1);
    idle(2);
    run_op(OP_XOR, 1'b0, 1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, OP_AND, NS, 1);
    idle(1);

    // Two slices of an abandoned op, then an async reset mid-operation.
    run_op(OP_ADD, 1'b0, 1'b0, 16'h0FFF, 16'h0FFF, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0, OP_XOR, 2, -1);
    @(negedge clk);
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_op", all_outs(), 32'd0);
    @(negedge clk);
    chk("reset_held", all_outs(), 32'd0);
    rst_n = 1'b1;
    h_cout = 1'b0; h_zero = 1'b0; h_ovf = 1'b0; h_neg = 1'b0;
    run_op(OP_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, OP_XOR, NS, -1);
    idle(1);

    run_op(OP_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, OP_OR,  NS, -1);
    run_op(OP_AND, 1'b0, 1'b1, 16'h00F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, NS, -1);
    idle(1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    idle(3);
    chk("sb_drain", sb_q.size(), 32'd0);
    chk("beat_count", n_seen, n_pushed);
    chk("idle_vld", {31'd0, o_vld}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
